// File: rtl/stack_if.sv
// Operand/result bundle between a sequencer (master) and the stack ALU (slave).
// Opcode and push operand go in; registered result, overflow flag and occupancy come back.
interface stack_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] out;
  logic             overflow;
  logic [31:0]      index;

  modport master (
    output in,
    output opcode,
    input  out,
    input  overflow,
    input  index
  );

  modport slave (
    input  in,
    input  opcode,
    output out,
    output overflow,
    output index
  );
endinterface

// File: rtl/stack.sv
// LIFO operand stack with a signed ALU: one opcode (push/pop/add/mul) per rising edge.
// Add and multiply read the top two entries non-destructively into the registered output.
module stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic    clk,
  input logic    rst_n,
  stack_if.slave bus
);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = $clog2(DEPTH);

  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpPush = 3'b110;
  localparam logic [2:0] OpPop  = 3'b111;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  logic [AddrW-1:0] wr_addr, top_addr, nxt_addr;
  logic             full, empty, has_two, do_push;
  logic [WIDTH-1:0] opa, opb, sum;
  logic             sum_ovf, mul_ovf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_hi;

  assign full     = (cnt_q == CntW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign has_two  = (cnt_q >= CntW'(2));
  assign wr_addr  = AddrW'(cnt_q);
  assign top_addr = AddrW'(cnt_q - CntW'(1));
  assign nxt_addr = AddrW'(cnt_q - CntW'(2));
  assign do_push  = (bus.opcode == OpPush) && !full;

  assign opa = mem[top_addr];
  assign opb = mem[nxt_addr];

  assign sum     = opa + opb;
  assign sum_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);

  // Sign-extend both operands so an unsigned 2W-bit multiply yields the signed product.
  assign prod    = {{WIDTH{opa[WIDTH-1]}}, opa} * {{WIDTH{opb[WIDTH-1]}}, opb};
  assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
  assign mul_ovf = !((&prod_hi) || !(|prod_hi));

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    ovf_d = ovf_q;
    if (bus.opcode[2]) begin
      ovf_d = 1'b0;
      unique case (bus.opcode)
        OpPush: begin
          if (!full) cnt_d = cnt_q + CntW'(1);
        end
        OpPop: begin
          if (!empty) begin
            out_d = opa;
            cnt_d = cnt_q - CntW'(1);
          end
        end
        OpAdd: begin
          if (has_two) begin
            out_d = sum;
            ovf_d = sum_ovf;
          end
        end
        OpMul: begin
          if (has_two) begin
            out_d = prod[WIDTH-1:0];
            ovf_d = mul_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is deliberately not reset; entries above the top are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= bus.in;
  end

  assign bus.out      = out_q;
  assign bus.overflow = ovf_q;
  assign bus.index    = 32'(cnt_q);
endmodule

// File: tb/tb_stack.sv
// Scoreboard bench for stack: stimulus pushes model expectations into a queue,
// a monitor pops and compares one entry after every executing clock edge.
module tb_stack;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] out;
    logic        ovf;
    logic [31:0] idx;
  } exp_t;

  logic clk;
  logic rst_n;

  stack_if #(.WIDTH(WIDTH)) bus ();

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] m_stk[$];
  logic [31:0] m_out;
  logic        m_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Monitor: each edge executes exactly one opcode, so one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.out !== e.out || bus.overflow !== e.ovf || bus.index !== e.idx) begin
        n_fail++;
        $display("FAIL op=%b: got out=%h ovf=%b index=%0d, expected out=%h ovf=%b index=%0d",
                 e.op, bus.out, bus.overflow, bus.index, e.out, e.ovf, e.idx);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] val);
    exp_t   e;
    int     a, b;
    longint r;
    @(negedge clk);
    bus.opcode = op;
    bus.in     = val;
    if (op[2]) begin
      m_ovf = 1'b0;
      case (op)
        3'b110: if (m_stk.size() < DEPTH) m_stk.push_back(val);
        3'b111: if (m_stk.size() > 0) m_out = m_stk.pop_back();
        default: begin
          if (m_stk.size() >= 2) begin
            a = int'(m_stk[m_stk.size()-1]);
            b = int'(m_stk[m_stk.size()-2]);
            r = (op == 3'b100) ? longint'(a) + longint'(b) : longint'(a) * longint'(b);
            m_out = r[31:0];
            m_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
          end
        end
      endcase
    end
    e.op  = op;
    e.out = m_out;
    e.ovf = m_ovf;
    e.idx = 32'(m_stk.size());
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Asserts reset mid-cycle after the monitor has drained, checks outputs without an edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.opcode = 3'b000;
    #1;
    check_now("reset out", bus.out, 32'h0);
    check_now("reset overflow", 32'(bus.overflow), 32'h0);
    check_now("reset index", bus.index, 32'h0);
    m_stk.delete();
    m_out = '0;
    m_ovf = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.in     = '0;
    bus.opcode = 3'b000;
    m_out      = '0;
    m_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_now("initial index", bus.index, 32'h0);
    rst_n = 1'b1;

    // Push/pop order, then ALU on 4000000 and -30000000.
    do_op(3'b110, 32'd1);
    do_op(3'b110, 32'd2);
    do_op(3'b110, -32'sd30000000);
    do_op(3'b110, 32'd4000000);
    do_op(3'b110, 32'd5);
    do_op(3'b111, '0);
    do_op(3'b100, '0);
    do_op(3'b101, '0);
    do_op(3'b100, '0);

    // Reset mid-sequence, then pop on empty.
    async_reset();
    do_op(3'b111, '0);

    // Add overflow, multiply without.
    do_op(3'b110, 32'h7FFF_FFFF);
    do_op(3'b110, 32'h1);
    do_op(3'b100, '0);
    do_op(3'b101, '0);

    // Full then empty, LIFO order.
    async_reset();
    for (int i = 0; i <= DEPTH; i++) do_op(3'b110, 32'(100 + i));
    for (int i = 0; i <= DEPTH; i++) do_op(3'b111, '0);

    // Single entry ALU is ignored; no-op holds state.
    do_op(3'b110, 32'd77);
    do_op(3'b111, '0);
    do_op(3'b110, 32'd9);
    do_op(3'b100, '0);
    do_op(3'b101, '0);
    repeat (4) do_op(3'b011, 32'hDEAD_BEEF);

    // Random traffic with a bias towards small operands so products fit.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  op;
      logic [31:0] v;
      op = 3'($urandom_range(0, 7));
      v  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
      do_op(op, v);
      if (i == 1500) async_reset();
    end

    repeat (3) @(posedge clk);
    #3;
    check_now("queue drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
